// File: rtl/mult_div_unit_if.sv
// -----------------------------------------------------------------------------
// mult_div_unit_if
//
// Purpose:
//   Bundles the execute-stage request/response signals of the multiply/divide
//   unit. The EX stage (master) issues operations and reads back the HI/LO
//   registers and the Busy flag used by the hazard unit; the multiply/divide
//   unit itself is the slave.
//
// Signals:
//   Start  master->slave  1   launch the operation selected by MDOp
//   MDOp   master->slave  3   000 mult, 001 multu, 010 div, 011 divu,
//                             100 mthi, 101 mtlo, 110/111 no-op
//   A      master->slave  32  rs operand (dividend / multiplicand / mthi-mtlo)
//   B      master->slave  32  rt operand (divisor / multiplier)
//   Busy   slave->master  1   high while a mult/div is in flight
//   HI     slave->master  32  architectural HI register
//   LO     slave->master  32  architectural LO register
// -----------------------------------------------------------------------------
interface mult_div_unit_if;
    logic        Start;
    logic [2:0]  MDOp;
    logic [31:0] A;
    logic [31:0] B;
    logic        Busy;
    logic [31:0] HI;
    logic [31:0] LO;

    modport master (
        output Start, MDOp, A, B,
        input  Busy, HI, LO
    );

    modport slave (
        input  Start, MDOp, A, B,
        output Busy, HI, LO
    );
endinterface : mult_div_unit_if

// File: rtl/mult_div_unit.sv
// -----------------------------------------------------------------------------
// mult_div_unit
//
// Purpose:
//   Execute-stage multiply/divide unit. Runs mult/multu/div/divu over a fixed
//   latency (MULT_CYCLES / DIV_CYCLES) and owns the architectural HI/LO
//   registers; also executes mthi/mtlo in a single cycle while idle.
//
//   The operands and opcode are latched at launch, the counter counts the
//   busy cycles down, and the arithmetic is evaluated from the latched
//   operands so that A/B may change freely while the unit is busy. HI/LO are
//   written only on the final busy cycle, at the same edge that drops Busy.
//
// Ports:
//   clk    input   1   rising-edge clock
//   reset  input   1   asynchronous, active-high; clears all state
//   md     slave modport of mult_div_unit_if (Start, MDOp, A, B -> Busy, HI, LO)
//
// Parameters:
//   MULT_CYCLES  cycles Busy stays high for mult/multu (>= 1)
//   DIV_CYCLES   cycles Busy stays high for div/divu   (>= 1)
// -----------------------------------------------------------------------------
module mult_div_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic            clk,
    input  logic            reset,
    mult_div_unit_if.slave  md
);

    // -------------------------------------------------------------------------
    // Types and constants
    // -------------------------------------------------------------------------
    typedef enum logic [2:0] {
        OP_MULT  = 3'b000,
        OP_MULTU = 3'b001,
        OP_DIV   = 3'b010,
        OP_DIVU  = 3'b011,
        OP_MTHI  = 3'b100,
        OP_MTLO  = 3'b101,
        OP_NOP0  = 3'b110,
        OP_NOP1  = 3'b111
    } md_op_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_e;

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    // The counter is loaded with N-1 at launch and the result is committed on
    // the cycle it reads zero, which gives exactly N busy cycles.
    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;
    md_op_e            op_q,    op_d;
    logic [31:0]       a_q,     a_d;
    logic [31:0]       b_q,     b_d;
    logic [31:0]       hi_q,    hi_d;
    logic [31:0]       lo_q,    lo_d;

    // -------------------------------------------------------------------------
    // Arithmetic on the latched operands
    // -------------------------------------------------------------------------
    logic        op_signed;
    logic        op_is_div;
    logic [63:0] mul_a_ext;
    logic [63:0] mul_b_ext;
    logic [63:0] mul_prod;
    logic [31:0] div_a_mag;
    logic [31:0] div_b_mag;
    logic [31:0] div_q_mag;
    logic [31:0] div_r_mag;
    logic        div_q_neg;
    logic        div_r_neg;
    logic [31:0] res_hi;
    logic [31:0] res_lo;

    // NOTE: every signal written in an always_comb gets a default value first;
    // a path that leaves one unassigned would otherwise infer a latch.
    always_comb begin
        op_signed = (op_q == OP_MULT) || (op_q == OP_DIV);
        op_is_div = (op_q == OP_DIV)  || (op_q == OP_DIVU);

        // One 64x64 multiplier serves both flavours: the low 64 bits of the
        // product of the sign- or zero-extended operands are the exact 32x32
        // signed or unsigned product.
        mul_a_ext = {{32{op_signed & a_q[31]}}, a_q};
        mul_b_ext = {{32{op_signed & b_q[31]}}, b_q};
        mul_prod  = mul_a_ext * mul_b_ext;

        // Signed division is done on magnitudes and the signs are reapplied:
        // the quotient is negative when the operand signs differ, and the
        // remainder takes the sign of the dividend. The overflow case
        // 8000_0000 / FFFF_FFFF falls out as quotient 8000_0000, remainder 0.
        div_a_mag = (op_signed && a_q[31]) ? (32'd0 - a_q) : a_q;
        div_b_mag = (op_signed && b_q[31]) ? (32'd0 - b_q) : b_q;
        div_q_mag = '0;
        div_r_mag = '0;
        if (b_q != 32'd0) begin
            div_q_mag = div_a_mag / div_b_mag;
            div_r_mag = div_a_mag % div_b_mag;
        end
        div_q_neg = op_signed && (a_q[31] ^ b_q[31]);
        div_r_neg = op_signed && a_q[31];

        if (!op_is_div) begin
            res_hi = mul_prod[63:32];
            res_lo = mul_prod[31:0];
        end else if (b_q == 32'd0) begin
            // Divide by zero: all-ones quotient, dividend left in HI.
            res_hi = a_q;
            res_lo = 32'hFFFF_FFFF;
        end else begin
            res_hi = div_r_neg ? (32'd0 - div_r_mag) : div_r_mag;
            res_lo = div_q_neg ? (32'd0 - div_q_mag) : div_q_mag;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;

        case (state_q)
            S_IDLE: begin
                if (md.Start) begin
                    case (md_op_e'(md.MDOp))
                        OP_MULT, OP_MULTU: begin
                            op_d    = md_op_e'(md.MDOp);
                            a_d     = md.A;
                            b_d     = md.B;
                            cnt_d   = MULT_LOAD;
                            state_d = S_BUSY;
                        end
                        OP_DIV, OP_DIVU: begin
                            op_d    = md_op_e'(md.MDOp);
                            a_d     = md.A;
                            b_d     = md.B;
                            cnt_d   = DIV_LOAD;
                            state_d = S_BUSY;
                        end
                        OP_MTHI: hi_d = md.A;
                        OP_MTLO: lo_d = md.A;
                        default: ; // 110/111 are no-ops
                    endcase
                end
            end

            S_BUSY: begin
                // Start is deliberately not looked at here: requests arriving
                // while busy, including mthi/mtlo, are dropped.
                if (cnt_q == '0) begin
                    hi_d    = res_hi;
                    lo_d    = res_lo;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= OP_MULT;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs (all straight from registers)
    // -------------------------------------------------------------------------
    assign md.Busy = (state_q == S_BUSY);
    assign md.HI   = hi_q;
    assign md.LO   = lo_q;

endmodule : mult_div_unit
